// File: rtl/sdram_sched_pkg.sv
// Shared types and helpers for the SDRAM access scheduler.
package sdram_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrGo,
    StWrWait,
    StRdGo,
    StRdWait,
    StErr
  } sched_state_e;

  localparam logic DirWrite = 1'b0;
  localparam logic DirRead  = 1'b1;

  // Legal bursts are powers of two in [4, region] so a burst never straddles the wrap.
  function automatic logic burst_len_illegal(input logic [31:0] len, input logic [31:0] region);
    return (len == 32'd0) || ((len & (len - 32'd1)) != 32'd0) || (len < 32'd4) || (len > region);
  endfunction

endpackage

// File: rtl/sdram_sched_ptr.sv
// Byte pointer into the circular capture region; advances by step and wraps at the region size.
module sdram_sched_ptr #(
  parameter logic [31:0] RegionBytes = 32'h0001_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic [31:0] step_i,
  output logic [31:0] ptr_o
);

  logic [31:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = 32'd0;
    end else if (adv_i) begin
      ptr_d = (ptr_q + step_i) & (RegionBytes - 32'd1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 32'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sdram_access_sched.sv
// Arbitrates SDRAM bursts between the capture writer and readback reader over a circular region.
module sdram_access_sched
  import sdram_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] REGION_BYTES   = 32'h0001_0000,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] cfg_burst_bytes,
  input  logic        clr_status,
  input  logic        wr_req,
  input  logic        rd_req,
  output logic        wr_grant,
  output logic        rd_grant,
  output logic        write_control_go,
  input  logic        write_control_done,
  output logic [31:0] control_write_base,
  output logic [31:0] control_write_length,
  output logic        write_control_fixed_location,
  output logic        read_control_go,
  input  logic        read_control_done,
  output logic [31:0] control_read_base,
  output logic [31:0] control_read_length,
  output logic        read_control_fixed_location,
  output logic [31:0] fill_bytes,
  output logic        busy,
  output logic        cfg_err,
  output logic        overflow,
  output logic        timeout_err
);

  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  sched_state_e state_d, state_q;
  logic [31:0]  len_d, len_q;
  logic [31:0]  fill_d, fill_q;
  logic [31:0]  cnt_d, cnt_q;
  logic         cfg_err_d, cfg_err_q;
  logic         last_d, last_q;
  logic         overflow_d, overflow_q;
  logic         timeout_d, timeout_q;
  logic         enable_q;

  logic         cfg_load, run_ok, wr_fits, rd_ok, wr_elig, rd_elig;
  logic         ovf_set, to_set, wr_adv, rd_adv, ptr_clr;
  logic [32:0]  fill_plus;
  logic [31:0]  wr_ptr, rd_ptr;

  assign cfg_load  = enable & ~enable_q & (state_q == StIdle);
  // Hold off grants in the latch cycle so eligibility never uses a stale length.
  assign run_ok    = enable & ~cfg_err_q & ~cfg_load;
  assign fill_plus = {1'b0, fill_q} + {1'b0, len_q};
  assign wr_fits   = fill_plus <= {1'b0, REGION_BYTES};
  assign rd_ok     = fill_q >= len_q;
  assign wr_elig   = run_ok & wr_req & wr_fits;
  assign rd_elig   = run_ok & rd_req & rd_ok;

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    cfg_err_d        = cfg_err_q;
    fill_d           = fill_q;
    last_d           = last_q;
    cnt_d            = cnt_q;
    ovf_set          = 1'b0;
    to_set           = 1'b0;
    wr_adv           = 1'b0;
    rd_adv           = 1'b0;
    ptr_clr          = 1'b0;
    write_control_go = 1'b0;
    read_control_go  = 1'b0;
    wr_grant         = 1'b0;
    rd_grant         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_load) begin
          len_d     = cfg_burst_bytes;
          cfg_err_d = burst_len_illegal(cfg_burst_bytes, REGION_BYTES);
        end else begin
          ovf_set = run_ok & wr_req & ~wr_fits;
          if (wr_elig && (!rd_elig || last_q == DirRead)) begin
            state_d = StWrGo;
          end else if (rd_elig) begin
            state_d = StRdGo;
          end
        end
      end
      StWrGo: begin
        write_control_go = 1'b1;
        wr_grant         = 1'b1;
        cnt_d            = 32'd0;
        state_d          = StWrWait;
      end
      StWrWait: begin
        if (write_control_done) begin
          wr_adv  = 1'b1;
          fill_d  = fill_q + len_q;
          last_d  = DirWrite;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          to_set  = 1'b1;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StRdGo: begin
        read_control_go = 1'b1;
        rd_grant        = 1'b1;
        cnt_d           = 32'd0;
        state_d         = StRdWait;
      end
      StRdWait: begin
        if (read_control_done) begin
          rd_adv  = 1'b1;
          fill_d  = fill_q - len_q;
          last_d  = DirRead;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          to_set  = 1'b1;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StErr: begin
        if (!enable) begin
          ptr_clr = 1'b1;
          fill_d  = 32'd0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    overflow_d = ovf_set | (overflow_q & ~clr_status);
    timeout_d  = to_set | (timeout_q & ~clr_status);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= 32'd0;
      fill_q     <= 32'd0;
      cnt_q      <= 32'd0;
      cfg_err_q  <= 1'b0;
      last_q     <= DirRead;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      cfg_err_q  <= cfg_err_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      enable_q   <= enable;
    end
  end

  sdram_sched_ptr #(
    .RegionBytes(REGION_BYTES)
  ) u_wr_ptr (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (ptr_clr),
    .adv_i (wr_adv),
    .step_i(len_q),
    .ptr_o (wr_ptr)
  );

  sdram_sched_ptr #(
    .RegionBytes(REGION_BYTES)
  ) u_rd_ptr (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (ptr_clr),
    .adv_i (rd_adv),
    .step_i(len_q),
    .ptr_o (rd_ptr)
  );

  assign control_write_base           = BASE_ADDR + wr_ptr;
  assign control_write_length         = len_q;
  assign write_control_fixed_location = 1'b1;
  assign control_read_base            = BASE_ADDR + rd_ptr;
  assign control_read_length          = len_q;
  assign read_control_fixed_location  = 1'b1;
  assign fill_bytes                   = fill_q;
  assign busy                         = (state_q != StIdle) && (state_q != StErr);
  assign cfg_err                      = cfg_err_q;
  assign overflow                     = overflow_q;
  assign timeout_err                  = timeout_q;

endmodule

// File: tb/tb_sdram_access_sched.sv
// Directed bench for sdram_access_sched: scoreboard of expected go transactions plus status checks.
module tb_sdram_access_sched;

  logic        clk = 1'b0;
  logic        reset, enable, clr_status, wr_req, rd_req;
  logic [31:0] cfg_burst_bytes;
  logic        wr_grant, rd_grant;
  logic        write_control_go, write_control_done, write_control_fixed_location;
  logic        read_control_go, read_control_done, read_control_fixed_location;
  logic [31:0] control_write_base, control_write_length;
  logic [31:0] control_read_base, control_read_length;
  logic [31:0] fill_bytes;
  logic        busy, cfg_err, overflow, timeout_err;

  always #5 clk = ~clk;

  sdram_access_sched #(
    .BASE_ADDR     (32'h0000_0000),
    .REGION_BYTES  (32'h0000_0100),
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .enable                      (enable),
    .cfg_burst_bytes             (cfg_burst_bytes),
    .clr_status                  (clr_status),
    .wr_req                      (wr_req),
    .rd_req                      (rd_req),
    .wr_grant                    (wr_grant),
    .rd_grant                    (rd_grant),
    .write_control_go            (write_control_go),
    .write_control_done          (write_control_done),
    .control_write_base          (control_write_base),
    .control_write_length        (control_write_length),
    .write_control_fixed_location(write_control_fixed_location),
    .read_control_go             (read_control_go),
    .read_control_done           (read_control_done),
    .control_read_base           (control_read_base),
    .control_read_length         (control_read_length),
    .read_control_fixed_location (read_control_fixed_location),
    .fill_bytes                  (fill_bytes),
    .busy                        (busy),
    .cfg_err                     (cfg_err),
    .overflow                    (overflow),
    .timeout_err                 (timeout_err)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] base;
    logic [31:0] len;
  } go_t;

  go_t exp_q[$];
  go_t obs_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  auto_done = 1'b1;
  int  wcnt = 0;
  int  rcnt = 0;

  function automatic go_t mk(input logic wr, input logic [31:0] base, input logic [31:0] len);
    go_t g;
    g.wr   = wr;
    g.base = base;
    g.len  = len;
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_go(input string tag, input logic wr, input logic [31:0] base,
                           input logic [31:0] len);
    int  n;
    go_t e, o;
    exp_q.push_back(mk(wr, base, len));
    n = 0;
    while (obs_q.size() == 0 && n < 200) begin
      cycles(1);
      n++;
    end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: no go observed, expected base=0x%0h", tag, e.base);
    end else begin
      o = obs_q.pop_front();
      chk({tag, "_dir"}, {31'd0, o.wr}, {31'd0, e.wr});
      chk({tag, "_base"}, o.base, e.base);
      chk({tag, "_len"}, o.len, e.len);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cycles(1);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Go monitor: records every go and flags both masters started together.
  initial begin
    forever begin
      @(negedge clk);
      if (write_control_go || read_control_go) begin
        checks++;
        assert (!(write_control_go && read_control_go)) else begin
          errors++;
          $error("FAIL dual_go: observed wr=%0b rd=%0b expected one", write_control_go,
                 read_control_go);
        end
        if (write_control_go) obs_q.push_back(mk(1'b1, control_write_base, control_write_length));
        else obs_q.push_back(mk(1'b0, control_read_base, control_read_length));
      end
    end
  end

  // Master models: done three cycles after go unless auto_done is cleared.
  initial begin
    write_control_done = 1'b0;
    read_control_done  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      write_control_done = 1'b0;
      read_control_done  = 1'b0;
      if (reset) begin
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0 && auto_done) write_control_done = 1'b1;
        end
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0 && auto_done) read_control_done = 1'b1;
        end
        if (write_control_go) wcnt = 3;
        if (read_control_go) rcnt = 3;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    enable = 1'b0;
    cfg_burst_bytes = 32'd0;
    clr_status = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    cycles(3);
    chk("rst_wgo", {31'd0, write_control_go}, 32'd0);
    chk("rst_rgo", {31'd0, read_control_go}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fill", fill_bytes, 32'd0);
    chk("rst_wbase", control_write_base, 32'd0);
    chk("rst_rbase", control_read_base, 32'd0);
    chk("rst_wlen", control_write_length, 32'd0);
    chk("rst_wfix", {31'd0, write_control_fixed_location}, 32'd1);
    chk("rst_rfix", {31'd0, read_control_fixed_location}, 32'd1);
    chk("rst_cfgerr", {31'd0, cfg_err}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_to", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    cycles(2);

    // Basic writes
    cfg_burst_bytes = 32'd64;
    enable = 1'b1;
    wr_req = 1'b1;
    expect_go("w1", 1'b1, 32'h00, 32'd64);
    expect_go("w2", 1'b1, 32'h40, 32'd64);
    chk("fill_w2", fill_bytes, 32'd64);
    wr_req = 1'b0;
    wait_idle("idle_w2");
    chk("fill_128", fill_bytes, 32'd128);

    // Fill to full, then overflow on the refused request
    wr_req = 1'b1;
    expect_go("w3", 1'b1, 32'h80, 32'd64);
    expect_go("w4", 1'b1, 32'hC0, 32'd64);
    wait_idle("idle_w4");
    cycles(10);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("fill_full", fill_bytes, 32'd256);
    chk("no_go_full", obs_q.size(), 32'd0);
    rd_req = 1'b1;
    expect_go("r1", 1'b0, 32'h00, 32'd64);
    rd_req = 1'b0;
    expect_go("w5_wrap", 1'b1, 32'h00, 32'd64);
    wr_req = 1'b0;
    wait_idle("idle_w5");
    chk("fill_full2", fill_bytes, 32'd256);
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Drain to 128
    rd_req = 1'b1;
    expect_go("r2", 1'b0, 32'h40, 32'd64);
    expect_go("r3", 1'b0, 32'h80, 32'd64);
    rd_req = 1'b0;
    wait_idle("idle_r3");
    chk("fill_drain", fill_bytes, 32'd128);

    // Alternation, last served was a read
    wr_req = 1'b1;
    rd_req = 1'b1;
    expect_go("a1", 1'b1, 32'h40, 32'd64);
    expect_go("a2", 1'b0, 32'hC0, 32'd64);
    expect_go("a3", 1'b1, 32'h80, 32'd64);
    expect_go("a4", 1'b0, 32'h00, 32'd64);
    wr_req = 1'b0;
    rd_req = 1'b0;
    wait_idle("idle_alt");
    chk("fill_alt", fill_bytes, 32'd128);
    chk("no_extra_alt", obs_q.size(), 32'd0);

    // Illegal burst lengths block all grants
    enable = 1'b0;
    cycles(2);
    cfg_burst_bytes = 32'd48;
    enable = 1'b1;
    cycles(2);
    chk("cfg48_err", {31'd0, cfg_err}, 32'd1);
    wr_req = 1'b1;
    rd_req = 1'b1;
    cycles(1000);
    chk("cfg48_nogo", obs_q.size(), 32'd0);
    enable = 1'b0;
    cycles(2);
    cfg_burst_bytes = 32'd0;
    enable = 1'b1;
    cycles(2);
    chk("cfg0_err", {31'd0, cfg_err}, 32'd1);
    cycles(100);
    chk("cfg0_nogo", obs_q.size(), 32'd0);
    wr_req = 1'b0;
    rd_req = 1'b0;
    enable = 1'b0;
    cycles(2);
    cfg_burst_bytes = 32'd64;
    enable = 1'b1;
    cycles(2);
    chk("cfg64_ok", {31'd0, cfg_err}, 32'd0);

    // Timeout with done withheld
    auto_done = 1'b0;
    wr_req = 1'b1;
    expect_go("t1", 1'b1, 32'hC0, 32'd64);
    wr_req = 1'b0;
    n = 0;
    while (!timeout_err && n < 100) begin
      cycles(1);
      n++;
    end
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    wr_req = 1'b1;
    rd_req = 1'b1;
    cycles(5);
    chk("err_nogo", obs_q.size(), 32'd0);
    wr_req = 1'b0;
    rd_req = 1'b0;
    enable = 1'b0;
    cycles(2);
    chk("err_fill_clr", fill_bytes, 32'd0);
    enable = 1'b1;
    auto_done = 1'b1;
    cycles(2);
    wr_req = 1'b1;
    expect_go("t2", 1'b1, 32'h00, 32'd64);
    wr_req = 1'b0;
    wait_idle("idle_t2");
    chk("fill_t2", fill_bytes, 32'd64);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    clr_status = 1'b1;
    cycles(1);
    clr_status = 1'b0;
    chk("to_clr", {31'd0, timeout_err}, 32'd0);

    // Asynchronous reset during WR_WAIT
    auto_done = 1'b0;
    wr_req = 1'b1;
    expect_go("rs1", 1'b1, 32'h40, 32'd64);
    wr_req = 1'b0;
    cycles(2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_go", {31'd0, write_control_go}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_fill", fill_bytes, 32'd0);
    cycles(2);
    reset = 1'b0;
    auto_done = 1'b1;
    wr_req = 1'b1;
    expect_go("rs2", 1'b1, 32'h00, 32'd64);
    wr_req = 1'b0;
    wait_idle("idle_rs2");
    chk("fill_rs2", fill_bytes, 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_access_sched.md
Name: sdram_access_sched

Overview:
- Schedules all SDRAM traffic for the capture path.
- Arbitrates between the ADC capture writer (write master) and the SPI readback reader (read master), so the two are never active together. This replaces the ad-hoc stop_write interlock.
- Owns the write and read pointers of a circular capture region, tracks fill level, and issues go/base/length to each master control port.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of region start; multiple of 4.
- REGION_BYTES, 32'h0001_0000, region size; power of two.
- TIMEOUT_CYCLES, 65535, max clk cycles waiting for a done before error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  scheduler run enable
- cfg_burst_bytes  in  32  burst length from SPI; sampled on enable rising edge
- clr_status  in  1  clears sticky overflow/timeout flags
- wr_req  in  1  capture has a burst ready
- rd_req  in  1  readback wants a burst
- wr_grant  out  1  1-cycle pulse: write burst started
- rd_grant  out  1  1-cycle pulse: read burst started
- write_control_go  out  1  write master go
- write_control_done  in  1  write master done
- control_write_base  out  32  write base address
- control_write_length  out  32  write length (bytes)
- write_control_fixed_location  out  1  constant 1
- read_control_go  out  1  read master go
- read_control_done  in  1  read master done
- control_read_base  out  32  read base address
- control_read_length  out  32  read length (bytes)
- read_control_fixed_location  out  1  constant 1
- fill_bytes  out  32  bytes written but not yet read
- busy  out  1  transaction outstanding
- cfg_err  out  1  latched burst length illegal
- overflow  out  1  sticky: wr_req refused because region full
- timeout_err  out  1  sticky: done not seen within TIMEOUT_CYCLES

Behaviour:
- Reset values: all outputs 0 except fixed_location=1 and bases=BASE_ADDR. wr_ptr=rd_ptr=0, last_served=READ, state=IDLE, len_q=0.
- Reset mid-transaction abandons it. The masters share the reset.
- Config: on enable 0->1 in IDLE, latch len_q=cfg_burst_bytes.
  - cfg_err=1 if len_q is 0, not a power of two, <4, or >REGION_BYTES.
  - While cfg_err is set, no grants are issued.
- Eligibility (IDLE only):
  - Write is eligible if wr_req && fill+len_q <= REGION_BYTES.
  - Read is eligible if rd_req && fill >= len_q.
  - wr_req while fill+len_q > REGION_BYTES sets overflow (sticky).
- Arbitration: if both are eligible, grant the one not equal to last_served; otherwise grant the eligible one. With none eligible, stay in IDLE. The decision is registered.
- States:
  - IDLE: a write grant goes to WR_GO, a read grant to RD_GO. Requires enable=1 && !cfg_err.
  - WR_GO (1 cycle): write_control_go=1, wr_grant=1, base=BASE_ADDR+wr_ptr, length=len_q. Next state WR_WAIT.
  - WR_WAIT: base/length held stable. On write_control_done:
    - wr_ptr=(wr_ptr+len_q)&(REGION_BYTES-1)
    - fill+=len_q
    - last_served=WRITE
    - next state IDLE.
  - RD_GO / RD_WAIT: mirror of the write states using rd_ptr and the read ports. On done, fill-=len_q and last_served=READ.
  - Timeout: in a WAIT state, if the counter reaches TIMEOUT_CYCLES, set timeout_err and go to ERR.
  - ERR: no go pulses. Exits to IDLE only when enable=0; pointers and fill are then cleared.
- done outside a WAIT state is ignored. go is never asserted in the same cycle as a WAIT state.
- enable dropped mid-transaction: the current transfer completes, then the block idles.
- Power-of-two len_q and region guarantee no burst straddles the wrap.
- fill is always within 0..REGION_BYTES. Equal pointers with fill=REGION_BYTES means full.
- busy=1 in every state except IDLE and ERR.
- clr_status clears overflow and timeout_err. A set in the same cycle wins over the clear.

Decomposition:
- Package sdram_sched_pkg holds:
  - state encoding (IDLE, WR_GO, WR_WAIT, RD_GO, RD_WAIT, ERR)
  - WRITE/READ constants for last_served
  - the cfg_err legality function
- One natural sub-module, sdram_sched_ptr: a wrapping pointer with an advance strobe and clear. It is instantiated twice, for write and read.

Test Plan:
- Reset, then enable with cfg=64 and wr_req held -> write_control_go pulses with base 0x0, length 64; after done, the next go has base 0x40 and fill_bytes=64.
- wr_req and rd_req both held, fill=128, len=64 -> grants alternate W, R, W, R. Go is never asserted on both masters in the same cycle.
- REGION_BYTES=256, len=64, four writes then a fifth wr_req -> no go issued and overflow=1. One read -> fifth write base=0x0 (wrap), fill=256.
- cfg_burst_bytes=48 or 0 on enable -> cfg_err=1 and zero go pulses for 1000 cycles despite requests.
- Write go issued with done withheld for TIMEOUT_CYCLES -> timeout_err=1, state ERR. enable=0 then 1 -> next write base=0x0.
- reset pulsed during WR_WAIT -> asynchronously go=0, busy=0, fill_bytes=0. The first post-reset write has base 0x0.
